prbschk_parallel_fab: RTL and testbench
=======================================

# prbschk_parallel_fab

Parallel PRBS7 checker that sits directly downstream of the parallel PRBS generator in the RX bit-alignment test path. It consumes one nbits-wide word per valid cycle from the deserialized or aligned lane and self-synchronizes to the incoming PRBS7 sequence (polynomial x^7 + x^6 + 1, MSB serialized first). It declares lock after a run of consecutive correct words and then counts word and bit errors against a free-running reference. Alignment-training logic and test benches use lock_o and the error counters as the pass/fail indicator for a lane.

## Interface
- nbits, 8: data word width; must be > 7.
- LOCK_CNT, 16: consecutive matching words required to lock; range 1..255.
- UNLOCK_CNT, 4: consecutive mismatching words while locked that drop lock; range 1..255.
- CNT_W, 16: width of the saturating error counters.

Ports:
- clk_i  in  1  single clock for all logic.
- reset_i  in  1  synchronous, active-high reset.
- chk_en_i  in  1  checker enable; low forces SEED and holds the counters.
- clear_i  in  1  zeroes both error counters and err_o; does not change the state.
- data_valid_i  in  1  data_i carries a word this cycle.
- data_i  in  nbits  received word, same bit order as the generator's prbs_out_o.
- lock_o  out  1  checker locked.
- err_o  out  1  one-cycle pulse: the last valid word mismatched while LOCKED.
- err_word_cnt_o  out  CNT_W  mismatching words while LOCKED, saturating.
- bit_err_cnt_o  out  CNT_W  total mismatching bits while LOCKED, saturating.

## Operation
- Prediction function P(W) gives the word following W:
  - Build e[nbits+6:0] with e[nbits+6:nbits] = W[6:0].
  - For i = nbits-1 down to 0: e[i] = e[i+7] ^ e[i+6].
  - P(W) = e[nbits-1:0].
  - For nbits = 8: P(0xFF) = 0x02 and P(0x02) = 0x0C.
- Internal registers: ref (nbits), good_cnt, bad_cnt.
- States: SEED, HUNT, LOCKED. Only cycles with data_valid_i = 1 advance the FSM.
- SEED: on a valid word, set ref <= data_i and good_cnt <= 0, then go to HUNT.
- HUNT (self-synchronizing):
  - A match is data_i == P(ref) and data_i != 0. The all-zero word is never a match, since it is a fixed point of P.
  - On a match, good_cnt increments; otherwise good_cnt <= 0.
  - ref <= data_i on every valid word.
  - When a match brings good_cnt to LOCK_CNT, go to LOCKED and set bad_cnt <= 0.
- LOCKED (free-running reference):
  - expected = P(ref); set ref <= expected (never reseeded from data).
  - mm = data_i ^ expected.
  - If mm != 0: err_o pulses, err_word_cnt_o += 1, bit_err_cnt_o += popcount(mm), bad_cnt += 1.
  - Otherwise bad_cnt <= 0.
  - When bad_cnt reaches UNLOCK_CNT, go to SEED.
- Counters:
  - Change only in LOCKED.
  - Saturate at all-ones; the bit counter clamps rather than wrapping when the addend overflows.
  - Retained across loss of lock.
- chk_en_i = 0: next state is SEED; lock_o, err_o, good_cnt and bad_cnt are 0; counters hold.
- clear_i: counters <= 0 and err_o <= 0 in the same cycle. Clear wins over a simultaneous error update. The FSM and lock are unaffected.

## Timing
- Reset: state SEED; lock_o, err_o, err_word_cnt_o, bit_err_cnt_o, ref, good_cnt and bad_cnt are all 0.
- All outputs are registered. err_o and the counters update one cycle after the valid word that caused them.
- lock_o rises one cycle after the valid word that makes the LOCK_CNT-th consecutive match. With continuous valid data, that is one cycle after word index LOCK_CNT, where the seed word is index 0.
- lock_o falls one cycle after the UNLOCK_CNT-th consecutive bad word. The first word after that is the new seed.
- data_valid_i gaps freeze all state: no prediction step and no counter change.
- Reset during LOCKED returns everything to reset values on the next edge.

## Test plan
- Lock from generator: feed a continuous generator stream starting 0xFF, 0x02, 0x0C, ...
  - lock_o = 1 one cycle after the 17th word.
  - err_o never asserts and both counters stay 0 over 1000 words.
- Single-bit error: after lock, XOR 0x01 into one word.
  - One err_o pulse; err_word_cnt_o = 1, bit_err_cnt_o = 1.
  - The next word matches; lock_o stays 1.
- Burst and unlock: after lock, corrupt 4 consecutive words with XOR 0xFF.
  - err_word_cnt_o = 4, bit_err_cnt_o = 32.
  - lock_o falls after the 4th bad word.
  - Relock occurs 17 clean words later; the counters keep 4 and 32.
- Zero and idle data: hold data_i = 0x00, then 0xA5, for 100 valid cycles each.
  - lock_o stays 0 and the counters stay 0.
- Saturation and clear: with CNT_W = 4, inject 20 single-bit errors while staying locked.
  - Both counters stop at 15.
  - Assert clear_i together with a 21st error: both counters read 0 and err_o is 0.
- Gaps and reset: toggle data_valid_i randomly during the stream; lock timing counts valid words only.
  - Assert reset_i mid-lock: all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/prbschk_parallel_fab.sv
// Parallel PRBS7 (x^7 + x^6 + 1) checker: self-synchronizes on incoming words,
// locks after a run of correct predictions, then counts word/bit errors against a free-running reference.
module prbschk_parallel_fab #(
    parameter int nbits      = 8,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             chk_en_i,
    input  logic             clear_i,
    input  logic             data_valid_i,
    input  logic [nbits-1:0] data_i,
    output logic             lock_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_word_cnt_o,
    output logic [CNT_W-1:0] bit_err_cnt_o
);

    localparam int PC_W = $clog2(nbits + 1);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [nbits-1:0] ref_q, ref_nxt;
    logic [7:0]       good_cnt, good_nxt;
    logic [7:0]       bad_cnt, bad_nxt;
    logic             lock_q;
    logic             err_q, err_nxt;
    logic [CNT_W-1:0] wcnt_q, wcnt_nxt;
    logic [CNT_W-1:0] bcnt_q, bcnt_nxt;
    logic [nbits-1:0] expected;
    logic [nbits-1:0] mm;
    logic             match;

    // Word that follows w in the serial PRBS7 stream (MSB transmitted first).
    function automatic logic [nbits-1:0] predict(input logic [nbits-1:0] w);
        logic [nbits+6:0] e;
        e = '0;
        e[nbits+6:nbits] = w[6:0];
        for (int i = nbits - 1; i >= 0; i--) begin
            e[i] = e[i+7] ^ e[i+6];
        end
        return e[nbits-1:0];
    endfunction

    function automatic logic [PC_W-1:0] popcount(input logic [nbits-1:0] w);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < nbits; i++) begin
            c = c + PC_W'(w[i]);
        end
        return c;
    endfunction

    // Saturating add: clamps to all-ones when the addend would overflow the counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
        logic [CNT_W+PC_W-1:0] s;
        s = {{PC_W{1'b0}}, a} + {{CNT_W{1'b0}}, b};
        if (|s[CNT_W+PC_W-1:CNT_W]) begin
            return {CNT_W{1'b1}};
        end
        return s[CNT_W-1:0];
    endfunction

    always_comb begin
        expected  = predict(ref_q);
        mm        = data_i ^ expected;
        // All-zero is a fixed point of the recurrence, so it can never count as sync.
        match     = (data_i == expected) && (|data_i);
        state_nxt = state;
        ref_nxt   = ref_q;
        good_nxt  = good_cnt;
        bad_nxt   = bad_cnt;
        err_nxt   = 1'b0;
        wcnt_nxt  = wcnt_q;
        bcnt_nxt  = bcnt_q;

        if (!chk_en_i) begin
            state_nxt = SEED;
            good_nxt  = '0;
            bad_nxt   = '0;
        end else if (data_valid_i) begin
            case (state)
                SEED: begin
                    ref_nxt   = data_i;
                    good_nxt  = '0;
                    state_nxt = HUNT;
                end
                HUNT: begin
                    ref_nxt = data_i;
                    if (match) begin
                        good_nxt = good_cnt + 8'd1;
                        if (good_cnt == 8'(LOCK_CNT - 1)) begin
                            state_nxt = LOCKED;
                            bad_nxt   = '0;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
                LOCKED: begin
                    ref_nxt = expected;
                    if (|mm) begin
                        err_nxt  = 1'b1;
                        wcnt_nxt = sat_add(wcnt_q, PC_W'(1));
                        bcnt_nxt = sat_add(bcnt_q, popcount(mm));
                        bad_nxt  = bad_cnt + 8'd1;
                        if (bad_cnt == 8'(UNLOCK_CNT - 1)) begin
                            state_nxt = SEED;
                        end
                    end else begin
                        bad_nxt = '0;
                    end
                end
                default: state_nxt = SEED;
            endcase
        end

        if (clear_i) begin
            wcnt_nxt = '0;
            bcnt_nxt = '0;
            err_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= SEED;
            ref_q    <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
            wcnt_q   <= '0;
            bcnt_q   <= '0;
        end else begin
            state    <= state_nxt;
            ref_q    <= ref_nxt;
            good_cnt <= good_nxt;
            bad_cnt  <= bad_nxt;
            lock_q   <= (state_nxt == LOCKED);
            err_q    <= err_nxt;
            wcnt_q   <= wcnt_nxt;
            bcnt_q   <= bcnt_nxt;
        end
    end

    assign lock_o         = lock_q;
    assign err_o          = err_q;
    assign err_word_cnt_o = wcnt_q;
    assign bit_err_cnt_o  = bcnt_q;

endmodule

// File: tb/tb_prbschk_parallel_fab.sv
// Bench for prbschk_parallel_fab: table of directed vectors plus hand-written
// sequences for saturation, clear, random gaps and reset while locked.
module tb_prbschk_parallel_fab;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       chk_en_i;
    logic       clear_i;
    logic       data_valid_i;
    logic [7:0] data_i;

    logic        lock16, err16;
    logic [15:0] wc16, bc16;
    logic        lock4, err4;
    logic [3:0]  wc4, bc4;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    prbschk_parallel_fab #(.nbits(8), .LOCK_CNT(16), .UNLOCK_CNT(4), .CNT_W(16)) dut16 (
        .clk_i(clk_i), .reset_i(reset_i), .chk_en_i(chk_en_i), .clear_i(clear_i),
        .data_valid_i(data_valid_i), .data_i(data_i), .lock_o(lock16), .err_o(err16),
        .err_word_cnt_o(wc16), .bit_err_cnt_o(bc16));

    prbschk_parallel_fab #(.nbits(8), .LOCK_CNT(16), .UNLOCK_CNT(4), .CNT_W(4)) dut4 (
        .clk_i(clk_i), .reset_i(reset_i), .chk_en_i(chk_en_i), .clear_i(clear_i),
        .data_valid_i(data_valid_i), .data_i(data_i), .lock_o(lock4), .err_o(err4),
        .err_word_cnt_o(wc4), .bit_err_cnt_o(bc4));

    // Serial PRBS7 source: b[n] = b[n-7] ^ b[n-6]; stream starts with word 0xFF.
    logic [6:0] hist;
    bit         gen_first;

    task automatic gen_next(output logic [7:0] w);
        logic nb;
        if (gen_first) begin
            gen_first = 1'b0;
            hist      = 7'h7F;
            w         = 8'hFF;
        end else begin
            for (int i = 7; i >= 0; i--) begin
                nb   = hist[6] ^ hist[5];
                hist = {hist[5:0], nb};
                w[i] = nb;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit v, input bit en, input bit clr, input bit rst,
                         input logic [7:0] d);
        data_valid_i = v;
        chk_en_i     = en;
        clear_i      = clr;
        reset_i      = rst;
        data_i       = d;
    endtask

    task automatic do_reset();
        drive(0, 1, 0, 1, 8'h00);
        @(negedge clk_i);
        reset_i   = 1'b0;
        gen_first = 1'b1;
        chk("rst_lock16", 32'(lock16), 0);
        chk("rst_err16", 32'(err16), 0);
        chk("rst_wc16", 32'(wc16), 0);
        chk("rst_bc16", 32'(bc16), 0);
        chk("rst_lock4", 32'(lock4), 0);
        chk("rst_bc4", 32'(bc4), 0);
    endtask

    typedef struct {
        bit         vld;
        bit         en;
        bit         clr;
        bit         gen;
        logic [7:0] val;
        bit         e_lock;
        bit         e_err;
        int         e_wc;
        int         e_bc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit vld, bit en, bit clr, bit gen, logic [7:0] val,
                                bit lk, bit er, int wc, int bc);
        vec_t r;
        r.vld = vld; r.en = en; r.clr = clr; r.gen = gen; r.val = val;
        r.e_lock = lk; r.e_err = er; r.e_wc = wc; r.e_bc = bc;
        tbl.push_back(r);
    endfunction

    initial begin
        logic [7:0] w;
        int         nvalid;
        int         exp_sat;

        drive(0, 1, 0, 1, 8'h00);
        gen_first = 1'b1;
        hist      = 7'h7F;
        do_reset();

        // Lock from generator with two gap cycles, then error/burst/unlock/relock.
        add(1, 1, 0, 1, 8'h00, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) add(1, 1, 0, 1, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 0, 0, 8'h5A, 0, 0, 0, 0);
        for (int i = 9; i <= 15; i++) add(1, 1, 0, 1, 8'h00, 0, 0, 0, 0);
        add(1, 1, 0, 1, 8'h00, 1, 0, 0, 0);
        for (int i = 0; i < 1000; i++) add(1, 1, 0, 1, 8'h00, 1, 0, 0, 0);
        add(1, 1, 0, 1, 8'h01, 1, 1, 1, 1);
        add(1, 1, 0, 1, 8'h00, 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) add(1, 1, 0, 1, 8'h00, 1, 0, 1, 1);
        add(1, 1, 1, 1, 8'h00, 1, 0, 0, 0);
        for (int k = 1; k <= 3; k++) add(1, 1, 0, 1, 8'hFF, 1, 1, k, 8 * k);
        add(1, 1, 0, 1, 8'hFF, 0, 1, 4, 32);
        for (int i = 0; i < 16; i++) add(1, 1, 0, 1, 8'h00, 0, 0, 4, 32);
        add(1, 1, 0, 1, 8'h00, 1, 0, 4, 32);
        add(1, 0, 0, 1, 8'h00, 0, 0, 4, 32);
        add(1, 0, 0, 1, 8'hFF, 0, 0, 4, 32);

        foreach (tbl[n]) begin
            if (tbl[n].gen && tbl[n].vld) begin
                gen_next(w);
                w = w ^ tbl[n].val;
            end else begin
                w = tbl[n].val;
            end
            drive(tbl[n].vld, tbl[n].en, tbl[n].clr, 0, w);
            @(negedge clk_i);
            chk($sformatf("tbl%0d_lock", n), 32'(lock16), 32'(tbl[n].e_lock));
            chk($sformatf("tbl%0d_err", n), 32'(err16), 32'(tbl[n].e_err));
            chk($sformatf("tbl%0d_wc", n), 32'(wc16), tbl[n].e_wc);
            chk($sformatf("tbl%0d_bc", n), 32'(bc16), tbl[n].e_bc);
            chk($sformatf("tbl%0d_lock4", n), 32'(lock4), 32'(tbl[n].e_lock));
        end

        // Zero and constant idle data never lock.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            drive(1, 1, 0, 0, (i < 100) ? 8'h00 : 8'hA5);
            @(negedge clk_i);
            chk("idle_lock", 32'(lock16), 0);
        end
        chk("idle_wc", 32'(wc16), 0);
        chk("idle_bc", 32'(bc16), 0);

        // Lock with random valid gaps: only valid words count.
        do_reset();
        nvalid = 0;
        for (int c = 0; c < 300 && nvalid < 17; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                gen_next(w);
                nvalid++;
                drive(1, 1, 0, 0, w);
            end else begin
                drive(0, 1, 0, 0, 8'($urandom));
            end
            @(negedge clk_i);
            chk("gap_lock16", 32'(lock16), (nvalid >= 17) ? 1 : 0);
            chk("gap_lock4", 32'(lock4), (nvalid >= 17) ? 1 : 0);
        end
        chk("gap_nvalid", nvalid, 17);

        // Saturation: isolated single-bit errors so lock is kept.
        for (int k = 1; k <= 20; k++) begin
            gen_next(w);
            drive(1, 1, 0, 0, w ^ 8'h01);
            @(negedge clk_i);
            exp_sat = (k > 15) ? 15 : k;
            chk("sat_err4", 32'(err4), 1);
            chk("sat_wc4", 32'(wc4), exp_sat);
            chk("sat_bc4", 32'(bc4), exp_sat);
            chk("sat_wc16", 32'(wc16), k);
            gen_next(w);
            drive(1, 1, 0, 0, w);
            @(negedge clk_i);
            chk("sat_clean_err4", 32'(err4), 0);
            chk("sat_lock4", 32'(lock4), 1);
        end

        // Clear wins over a simultaneous error.
        gen_next(w);
        drive(1, 1, 1, 0, w ^ 8'h01);
        @(negedge clk_i);
        chk("clr_wc4", 32'(wc4), 0);
        chk("clr_bc4", 32'(bc4), 0);
        chk("clr_err4", 32'(err4), 0);
        chk("clr_wc16", 32'(wc16), 0);
        chk("clr_err16", 32'(err16), 0);
        chk("clr_lock4", 32'(lock4), 1);

        // Bit counter clamps when the popcount addend overflows it.
        gen_next(w);
        drive(1, 1, 0, 0, w ^ 8'hFF);
        @(negedge clk_i);
        chk("clamp1_bc4", 32'(bc4), 8);
        gen_next(w);
        drive(1, 1, 0, 0, w);
        @(negedge clk_i);
        gen_next(w);
        drive(1, 1, 0, 0, w ^ 8'hFF);
        @(negedge clk_i);
        chk("clamp2_bc4", 32'(bc4), 15);
        chk("clamp2_wc4", 32'(wc4), 2);
        chk("clamp2_bc16", 32'(bc16), 16);
        chk("clamp2_lock4", 32'(lock4), 1);

        // Reset while locked.
        gen_next(w);
        drive(1, 1, 0, 1, w);
        @(negedge clk_i);
        chk("rstlk_lock16", 32'(lock16), 0);
        chk("rstlk_err16", 32'(err16), 0);
        chk("rstlk_wc16", 32'(wc16), 0);
        chk("rstlk_bc16", 32'(bc16), 0);
        chk("rstlk_lock4", 32'(lock4), 0);
        chk("rstlk_wc4", 32'(wc4), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
